boost_pwm_ctrl: RTL

- Digital closed-loop controller for the boost power stage. It drives the switch-control input with a fixed-frequency PWM and regulates the output voltage from ADC samples using integral control.
- Includes soft-start, a maximum-duty clamp and an over-voltage fault latch.
- Sits between the output-voltage ADC and the gate-drive net of the boost stage.

---
 rtl/boost_pwm_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/boost_pwm_ctrl.sv
// Closed-loop boost converter controller: fixed-frequency PWM with integral
// regulation from ADC samples, soft-start ramp, duty clamp and over-voltage latch.
module boost_pwm_ctrl #(
  parameter int CNT_W     = 12,
  parameter int PERIOD    = 2500,
  parameter int ADC_W     = 12,
  parameter int DUTY_MAX  = 2250,
  parameter int KI_SHIFT  = 4,
  parameter int SS_STEP   = 8,
  parameter int OVP_LIMIT = 3900
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ADC_W-1:0] vref,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic             adc_ready,
  output logic             period_start,
  output logic             pwm_out,
  output logic [CNT_W-1:0] duty,
  output logic [1:0]       state,
  output logic             fault
);

  localparam int ACC_W = CNT_W + KI_SHIFT;
  localparam int SUM_W = ACC_W + 2;
  localparam logic [ACC_W-1:0] ACC_MAX  = ACC_W'(DUTY_MAX * (2 ** KI_SHIFT));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [ADC_W-1:0] OVP_CODE = ADC_W'(OVP_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SOFTSTART = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] duty_cmd_r;
  logic [CNT_W-1:0] duty_active_r;
  logic [ACC_W-1:0] acc_r;
  logic [ADC_W-1:0] ss_ref_r;
  logic             pwm_r;
  logic             period_start_r;
  logic             adc_ready_r;
  logic             fault_r;

  logic                    run_s;
  logic                    wrap_s;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic [CNT_W-1:0]        duty_nxt_s;
  logic                    accept_s;
  logic                    ovp_s;
  logic [ADC_W-1:0]        ref_eff_s;
  logic signed [ADC_W:0]   err_s;
  logic signed [SUM_W-1:0] sum_s;
  logic [ACC_W-1:0]        acc_sat_s;
  logic [ADC_W:0]          ss_sum_s;
  logic                    ss_hit_s;
  logic [ADC_W-1:0]        ss_next_s;

  // Next-period counter, integrator update with saturation and soft-start ramp step.
  always_comb begin
    run_s  = (state_r == ST_SOFTSTART) || (state_r == ST_RUN);
    wrap_s = run_s && (cnt_r == CNT_LAST);
    if (wrap_s) begin
      cnt_nxt_s  = CNT_W'(0);
      duty_nxt_s = duty_cmd_r;
    end else begin
      cnt_nxt_s  = cnt_r + CNT_W'(1);
      duty_nxt_s = duty_active_r;
    end
    accept_s = adc_valid && adc_ready_r;
    ovp_s    = accept_s && (adc_data > OVP_CODE);
    if (state_r == ST_SOFTSTART) begin
      ref_eff_s = ss_ref_r;
    end else begin
      ref_eff_s = vref;
    end
    err_s = $signed({1'b0, ref_eff_s}) - $signed({1'b0, adc_data});
    sum_s = $signed({2'b00, acc_r}) + SUM_W'(err_s);
    if (sum_s[SUM_W-1]) begin
      acc_sat_s = ACC_W'(0);
    end else if (sum_s > $signed({2'b00, ACC_MAX})) begin
      acc_sat_s = ACC_MAX;
    end else begin
      acc_sat_s = sum_s[ACC_W-1:0];
    end
    ss_sum_s = {1'b0, ss_ref_r} + (ADC_W+1)'(SS_STEP);
    ss_hit_s = (ss_sum_s >= {1'b0, vref});
    if (ss_hit_s) begin
      ss_next_s = vref;
    end else begin
      ss_next_s = ss_sum_s[ADC_W-1:0];
    end
  end

  // Controller FSM; outputs are registered from next-cycle values so they line up with cnt_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      cnt_r          <= CNT_W'(0);
      duty_cmd_r     <= CNT_W'(0);
      duty_active_r  <= CNT_W'(0);
      acc_r          <= ACC_W'(0);
      ss_ref_r       <= ADC_W'(0);
      pwm_r          <= 1'b0;
      period_start_r <= 1'b0;
      adc_ready_r    <= 1'b0;
      fault_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r         <= CNT_W'(0);
          duty_cmd_r    <= CNT_W'(0);
          duty_active_r <= CNT_W'(0);
          acc_r         <= ACC_W'(0);
          ss_ref_r      <= ADC_W'(0);
          pwm_r         <= 1'b0;
          fault_r       <= 1'b0;
          if (enable) begin
            state_r        <= ST_SOFTSTART;
            period_start_r <= 1'b1;
            adc_ready_r    <= 1'b1;
          end else begin
            period_start_r <= 1'b0;
            adc_ready_r    <= 1'b0;
          end
        end
        ST_SOFTSTART, ST_RUN: begin
          if (ovp_s) begin
            // Over-voltage beats both the integrator update and a simultaneous disable.
            state_r        <= ST_FAULT;
            fault_r        <= 1'b1;
            acc_r          <= ACC_W'(0);
            cnt_r          <= CNT_W'(0);
            duty_cmd_r     <= CNT_W'(0);
            duty_active_r  <= CNT_W'(0);
            pwm_r          <= 1'b0;
            period_start_r <= 1'b0;
            adc_ready_r    <= 1'b0;
          end else if (!enable) begin
            state_r        <= ST_IDLE;
            cnt_r          <= CNT_W'(0);
            duty_cmd_r     <= CNT_W'(0);
            duty_active_r  <= CNT_W'(0);
            pwm_r          <= 1'b0;
            period_start_r <= 1'b0;
            adc_ready_r    <= 1'b0;
          end else begin
            cnt_r          <= cnt_nxt_s;
            duty_active_r  <= duty_nxt_s;
            pwm_r          <= (cnt_nxt_s < duty_nxt_s);
            period_start_r <= (cnt_nxt_s == CNT_W'(0));
            adc_ready_r    <= 1'b1;
            if (accept_s) begin
              acc_r      <= acc_sat_s;
              duty_cmd_r <= CNT_W'(acc_sat_s >> KI_SHIFT);
            end
            if (wrap_s && (state_r == ST_SOFTSTART)) begin
              ss_ref_r <= ss_next_s;
              if (ss_hit_s) begin
                state_r <= ST_RUN;
              end
            end
          end
        end
        ST_FAULT: begin
          cnt_r          <= CNT_W'(0);
          acc_r          <= ACC_W'(0);
          pwm_r          <= 1'b0;
          period_start_r <= 1'b0;
          adc_ready_r    <= 1'b0;
          if (!enable) begin
            state_r <= ST_IDLE;
            fault_r <= 1'b0;
          end else begin
            fault_r <= 1'b1;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          pwm_r          <= 1'b0;
          period_start_r <= 1'b0;
          adc_ready_r    <= 1'b0;
          fault_r        <= 1'b0;
        end
      endcase
    end
  end

  assign adc_ready    = adc_ready_r;
  assign period_start = period_start_r;
  assign pwm_out      = pwm_r;
  assign duty         = duty_active_r;
  assign state        = state_r;
  assign fault        = fault_r;

endmodule
